alu_result_stage: RTL and testbench
===================================

Name: alu_result_stage

Overview:
- Downstream stage of the ALU. Captures the ALU's 64-bit result C together with its 5-bit opcode into the Z register pair (Z_hi/Z_lo).
- Derives zero/negative flags from the captured result.
- Sequences the result onto the 32-bit writeback path over a valid/ready handshake:
  - single-word ops: one beat to a GPR;
  - MUL/DIV: two beats, LO then HI.
- Sits between the ALU output and the register-file/HI-LO write port.

Parameters:
- DATA_W, 32, word width; Z is 2*DATA_W. Only 32 is verified.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- clear  in  1  asynchronous, active-high reset
- alu_c  in  64  ALU result C
- alu_op  in  5  ALU opcode matching alu_c: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 SHR, 5 SHRA, 6 SHL, 7 ROR, 8 ROL, 9 AND, 10 OR, 11 NEG, 12 NOT
- cap_valid  in  1  capture request (control sequencer "Zin")
- cap_ready  out  1  stage can accept a capture this cycle
- flush  in  1  synchronous abort of pending writeback
- z_hi  out  32  Z register upper word
- z_lo  out  32  Z register lower word
- zero_flag  out  1  captured result is zero
- neg_flag  out  1  captured result is negative
- wb_valid  out  1  writeback beat presented
- wb_ready  in  1  writeback consumer accepts the beat
- wb_data  out  32  writeback word
- wb_sel  out  2  writeback destination: 00 GPR, 01 LO, 10 HI, 11 unused (never driven)
- busy  out  1  state != IDLE

Behaviour:
- Reset (clear=1, asynchronous):
  - state = IDLE; z_hi = z_lo = 0; zero_flag = 0; neg_flag = 0
  - wb_valid = 0; wb_data = 0; wb_sel = 00; busy = 0
  - cap_ready = 1 once clear deasserts
  - Reset mid-sequence drops the pending beats; no partial writeback persists.
- States: IDLE, WB_GPR, WB_LO, WB_HI.
- Capture fires on cap_valid & cap_ready at a rising edge:
  - Z <= alu_c; op register <= alu_op.
  - Wide op (alu_op = 2 or 3): next state WB_LO.
  - Any other op, including undefined codes 13..31: next state WB_GPR.
  - cap_valid while cap_ready = 0 is ignored; Z and flags are unchanged.
- Flags update only on capture:
  - Wide op: zero_flag = (alu_c == 0); neg_flag = alu_c[63].
  - Narrow op: zero_flag = (alu_c[31:0] == 0); neg_flag = alu_c[31]. Upper word is ignored.
- Z storage: z_hi = C[63:32], z_lo = C[31:0], loaded as-is. Narrow ops arrive zero-extended from the ALU and are stored as given (no masking).
- Writeback beats:
  - WB_GPR: wb_valid = 1, wb_data = z_lo, wb_sel = 00.
  - WB_LO: wb_valid = 1, wb_data = z_lo, wb_sel = 01.
  - WB_HI: wb_valid = 1, wb_data = z_hi, wb_sel = 10.
  - wb_valid, wb_data and wb_sel are registered. They assert the cycle after capture and hold stable until wb_ready is sampled high.
  - Transitions on accept: WB_GPR -> IDLE; WB_LO -> WB_HI; WB_HI -> IDLE.
  - wb_ready low stalls indefinitely with no timeout. wb_ready while wb_valid = 0 has no effect.
- Latency:
  - capture to first beat valid: 1 cycle.
  - narrow op occupies 2 cycles minimum; wide op 3 cycles minimum.
- cap_ready = (state == IDLE) | (final beat accepted this cycle), i.e. WB_GPR or WB_HI with wb_ready = 1.
  - Back-to-back: a new capture in the same cycle as the final accept loads the new Z, and the next beat appears with no bubble.
  - cap_ready is combinational from wb_ready. There is no path from cap_valid to wb_ready.
- flush:
  - Sampled high: state -> IDLE, wb_valid = 0 next cycle.
  - Z and flags are retained.
  - A beat accepted in the same cycle counts as delivered.
  - flush has priority over a simultaneous capture; the capture is dropped.
- busy = 1 in WB_GPR, WB_LO and WB_HI.

Decomposition:
- Shared package (alu_pkg): ALU opcode localparams (ALU_ADD..ALU_NOT, values 0..12), wb_sel encodings (WB_GPR = 2'b00, WB_LO = 2'b01, WB_HI = 2'b10), state encoding.
- The ALU module imports the same opcode constants from this package.
- No sub-module is needed. One flag helper function (is_wide_op) lives in the package.

Test Plan:
- Reset: assert clear mid-WB_HI -> all outputs 0 immediately; after release cap_ready = 1, busy = 0.
- ADD: alu_op = 0, alu_c = 0x0000_0000_0000_0000, wb_ready = 1 -> zero_flag = 1, neg_flag = 0; one beat wb_data = 0, wb_sel = 00; IDLE after 2 cycles.
- MUL: alu_op = 2, alu_c = 0xFFFF_FFFF_8000_0000, wb_ready = 1 -> neg_flag = 1, zero_flag = 0; beat 1 wb_sel = 01, wb_data = 0x8000_0000; beat 2 wb_sel = 10, wb_data = 0xFFFF_FFFF.
- Stall: DIV alu_c = 0x0000_0003_0000_0005, wb_ready = 0 for 4 cycles -> wb_data = 5 / wb_sel = 01 held stable, cap_ready = 0; cap_valid pulse with other data ignored.
- Back-to-back: SUB result 0x0000_0000_8000_0001 (neg_flag = 1), then AND captured in the accept cycle -> second beat on the very next cycle, no bubble.
- Flush: in WB_LO assert flush together with cap_valid -> IDLE next cycle, wb_valid = 0, z_hi/z_lo and flags unchanged, capture dropped.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, writeback destination encodings, result-stage
// state encoding and the wide-op classifier used by both the ALU and its result stage.
package alu_pkg;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_MUL  = 5'd2;
    localparam logic [4:0] ALU_DIV  = 5'd3;
    localparam logic [4:0] ALU_SHR  = 5'd4;
    localparam logic [4:0] ALU_SHRA = 5'd5;
    localparam logic [4:0] ALU_SHL  = 5'd6;
    localparam logic [4:0] ALU_ROR  = 5'd7;
    localparam logic [4:0] ALU_ROL  = 5'd8;
    localparam logic [4:0] ALU_AND  = 5'd9;
    localparam logic [4:0] ALU_OR   = 5'd10;
    localparam logic [4:0] ALU_NEG  = 5'd11;
    localparam logic [4:0] ALU_NOT  = 5'd12;

    localparam logic [1:0] WB_GPR = 2'b00;
    localparam logic [1:0] WB_LO  = 2'b01;
    localparam logic [1:0] WB_HI  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WB_GPR = 2'd1,
        ST_WB_LO  = 2'd2,
        ST_WB_HI  = 2'd3
    } state_t;

    // MUL/DIV produce a full 64-bit result written as a LO/HI pair.
    function automatic logic is_wide_op(input logic [4:0] op);
        return (op == ALU_MUL) || (op == ALU_DIV);
    endfunction

endpackage

// File: rtl/alu_result_stage.sv
// ALU result stage: captures C into Z, derives zero/neg flags and streams the
// result to the register file as one GPR beat or a LO-then-HI pair.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                clear,
    input  logic [2*DATA_W-1:0] alu_c,
    input  logic [4:0]          alu_op,
    input  logic                cap_valid,
    output logic                cap_ready,
    input  logic                flush,
    output logic [DATA_W-1:0]   z_hi,
    output logic [DATA_W-1:0]   z_lo,
    output logic                zero_flag,
    output logic                neg_flag,
    output logic                wb_valid,
    input  logic                wb_ready,
    output logic [DATA_W-1:0]   wb_data,
    output logic [1:0]          wb_sel,
    output logic                busy
);

    state_t              state_q, state_d;
    logic [4:0]          op_q;
    logic                accept, last_accept, cap_fire;
    logic [DATA_W-1:0]   z_hi_d, z_lo_d;
    logic                wb_valid_d;
    logic [DATA_W-1:0]   wb_data_d;
    logic [1:0]          wb_sel_d;

    assign accept      = wb_valid & wb_ready;
    assign last_accept = accept & ((state_q == ST_WB_GPR) | (state_q == ST_WB_HI));
    assign cap_ready   = (state_q == ST_IDLE) | last_accept;
    // flush wins over a coincident capture
    assign cap_fire    = cap_valid & cap_ready & ~flush;
    assign busy        = (state_q != ST_IDLE);

    always_ff @(posedge clk or posedge clear) begin
        if (clear) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_WB_GPR: if (accept) state_d = ST_IDLE;
                ST_WB_LO:  if (accept) state_d = is_wide_op(op_q) ? ST_WB_HI : ST_IDLE;
                ST_WB_HI:  if (accept) state_d = ST_IDLE;
                default:   state_d = state_q;
            endcase
            if (cap_fire) state_d = is_wide_op(alu_op) ? ST_WB_LO : ST_WB_GPR;
        end
    end

    // Beat contents are precomputed from the next state and next Z so the
    // writeback outputs come straight from flops.
    always_comb begin
        z_hi_d     = cap_fire ? alu_c[2*DATA_W-1:DATA_W] : z_hi;
        z_lo_d     = cap_fire ? alu_c[DATA_W-1:0]        : z_lo;
        wb_valid_d = 1'b0;
        wb_data_d  = '0;
        wb_sel_d   = WB_GPR;
        case (state_d)
            ST_WB_GPR: begin wb_valid_d = 1'b1; wb_data_d = z_lo_d; wb_sel_d = WB_GPR; end
            ST_WB_LO:  begin wb_valid_d = 1'b1; wb_data_d = z_lo_d; wb_sel_d = WB_LO;  end
            ST_WB_HI:  begin wb_valid_d = 1'b1; wb_data_d = z_hi_d; wb_sel_d = WB_HI;  end
            default:   ;
        endcase
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            wb_valid <= 1'b0;
            wb_data  <= '0;
            wb_sel   <= WB_GPR;
        end else begin
            wb_valid <= wb_valid_d;
            wb_data  <= wb_data_d;
            wb_sel   <= wb_sel_d;
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            z_hi      <= '0;
            z_lo      <= '0;
            op_q      <= ALU_ADD;
            zero_flag <= 1'b0;
            neg_flag  <= 1'b0;
        end else if (cap_fire) begin
            z_hi <= z_hi_d;
            z_lo <= z_lo_d;
            op_q <= alu_op;
            if (is_wide_op(alu_op)) begin
                zero_flag <= (alu_c == '0);
                neg_flag  <= alu_c[2*DATA_W-1];
            end else begin
                zero_flag <= (alu_c[DATA_W-1:0] == '0);
                neg_flag  <= alu_c[DATA_W-1];
            end
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: expected beats are queued at capture
// and compared by a monitor whenever the stage hands over a beat.
module tb_alu_result_stage;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  s;
    } beat_t;

    logic        clk = 1'b0;
    logic        clear = 1'b1;
    logic [63:0] alu_c = '0;
    logic [4:0]  alu_op = '0;
    logic        cap_valid = 1'b0;
    logic        cap_ready;
    logic        flush = 1'b0;
    logic [31:0] z_hi, z_lo;
    logic        zero_flag, neg_flag;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic [31:0] wb_data;
    logic [1:0]  wb_sel;
    logic        busy;

    int n_chk = 0;
    int n_err = 0;
    beat_t sb[$];

    alu_result_stage #(.DATA_W(32)) dut (
        .clk(clk), .clear(clear), .alu_c(alu_c), .alu_op(alu_op),
        .cap_valid(cap_valid), .cap_ready(cap_ready), .flush(flush),
        .z_hi(z_hi), .z_lo(z_lo), .zero_flag(zero_flag), .neg_flag(neg_flag),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
        .wb_sel(wb_sel), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Monitor: every accepted beat must match the oldest expected beat.
    always @(negedge clk) begin
        if (!clear && wb_valid && wb_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", 64'(wb_data), 64'hx);
            end else begin
                beat_t e;
                e = sb.pop_front();
                chk("wb_data", 64'(wb_data), 64'(e.d));
                chk("wb_sel", 64'(wb_sel), 64'(e.s));
            end
        end
    end

    function automatic logic wide(input logic [4:0] op);
        return (op == 5'd2) || (op == 5'd3);
    endfunction

    // Drive a capture the bench expects to be accepted at the next edge.
    task automatic capture(input logic [4:0] op, input logic [63:0] c);
        alu_op = op; alu_c = c; cap_valid = 1'b1;
        @(negedge clk);
        chk("cap_ready", 64'(cap_ready), 64'd1);
        if (wide(op)) begin
            sb.push_back('{d: c[31:0], s: 2'b01});
            sb.push_back('{d: c[63:32], s: 2'b10});
        end else begin
            sb.push_back('{d: c[31:0], s: 2'b00});
        end
        @(posedge clk); #1;
        cap_valid = 1'b0;
    endtask

    task automatic idle_chk(input string tag);
        @(negedge clk);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_valid"}, 64'(wb_valid), 64'd0);
        chk({tag, "_rdy"}, 64'(cap_ready), 64'd1);
    endtask

    initial begin
        // reset values
        #2;
        chk("rst_zhi", 64'(z_hi), 64'd0);
        chk("rst_valid", 64'(wb_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        @(posedge clk); #1; clear = 1'b0;
        idle_chk("rst_rel");

        // ADD zero result, single GPR beat, idle two cycles later
        wb_ready = 1'b1;
        @(posedge clk); #1;
        capture(5'd0, 64'h0);
        @(negedge clk);
        chk("add_zero", 64'(zero_flag), 64'd1);
        chk("add_neg", 64'(neg_flag), 64'd0);
        chk("add_valid", 64'(wb_valid), 64'd1);
        chk("add_busy", 64'(busy), 64'd1);
        @(posedge clk); #1;
        idle_chk("add_done");

        // MUL: LO then HI
        @(posedge clk); #1;
        capture(5'd2, 64'hFFFF_FFFF_8000_0000);
        @(negedge clk);
        chk("mul_neg", 64'(neg_flag), 64'd1);
        chk("mul_zero", 64'(zero_flag), 64'd0);
        chk("mul_z", {z_hi, z_lo}, 64'hFFFF_FFFF_8000_0000);
        @(posedge clk); #1;
        @(posedge clk); #1;
        idle_chk("mul_done");

        // DIV stalled by consumer; a capture attempt during the stall is ignored
        @(posedge clk); #1;
        wb_ready = 1'b0;
        capture(5'd3, 64'h0000_0003_0000_0005);
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin alu_c = 64'hDEAD_BEEF_0000_0000; alu_op = 5'd0; cap_valid = 1'b1; end
            @(negedge clk);
            chk("stall_data", 64'(wb_data), 64'd5);
            chk("stall_sel", 64'(wb_sel), 64'd1);
            chk("stall_rdy", 64'(cap_ready), 64'd0);
            @(posedge clk); #1;
            cap_valid = 1'b0;
        end
        chk("stall_z", {z_hi, z_lo}, 64'h0000_0003_0000_0005);
        chk("stall_zero", 64'(zero_flag), 64'd0);
        wb_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        idle_chk("stall_done");

        // Back-to-back: AND captured in the SUB accept cycle, no bubble
        @(posedge clk); #1;
        capture(5'd1, 64'h0000_0000_8000_0001);
        alu_op = 5'd9; alu_c = 64'h0000_0000_0000_00F0; cap_valid = 1'b1;
        @(negedge clk);
        chk("sub_neg", 64'(neg_flag), 64'd1);
        chk("b2b_rdy", 64'(cap_ready), 64'd1);
        sb.push_back('{d: 32'h0000_00F0, s: 2'b00});
        @(posedge clk); #1;
        cap_valid = 1'b0;
        @(negedge clk);
        chk("b2b_valid", 64'(wb_valid), 64'd1);
        chk("and_neg", 64'(neg_flag), 64'd0);
        @(posedge clk); #1;
        idle_chk("b2b_done");

        // Undefined opcode: narrow, upper word stored but ignored by flags
        @(posedge clk); #1;
        capture(5'd20, 64'hFFFF_FFFF_0000_0000);
        @(negedge clk);
        chk("undef_zero", 64'(zero_flag), 64'd1);
        chk("undef_neg", 64'(neg_flag), 64'd0);
        chk("undef_zhi", 64'(z_hi), 64'hFFFF_FFFF);
        @(posedge clk); #1;
        idle_chk("undef_done");

        // Flush in WB_LO with a capture attempt: pending beats and capture dropped
        @(posedge clk); #1;
        wb_ready = 1'b0;
        capture(5'd3, 64'h0000_0001_0000_0000);
        flush = 1'b1; cap_valid = 1'b1; alu_op = 5'd0; alu_c = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk); #1;
        flush = 1'b0; cap_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("flush_valid", 64'(wb_valid), 64'd0);
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_z", {z_hi, z_lo}, 64'h0000_0001_0000_0000);
        chk("flush_zero", 64'(zero_flag), 64'd0);
        chk("flush_neg", 64'(neg_flag), 64'd0);

        // Flush during a final accept with cap_ready high: beat delivered, capture dropped
        wb_ready = 1'b1;
        @(posedge clk); #1;
        capture(5'd10, 64'h0000_0000_0000_0055);
        flush = 1'b1; cap_valid = 1'b1; alu_op = 5'd9; alu_c = 64'h0000_0000_0000_0077;
        @(posedge clk); #1;
        flush = 1'b0; cap_valid = 1'b0;
        @(negedge clk);
        chk("flush2_valid", 64'(wb_valid), 64'd0);
        chk("flush2_zlo", 64'(z_lo), 64'h55);

        // Reset asserted while in WB_HI
        @(posedge clk); #1;
        wb_ready = 1'b0;
        capture(5'd2, 64'hAAAA_AAAA_5555_5555);
        wb_ready = 1'b1;
        @(posedge clk); #1;
        wb_ready = 1'b0;
        @(negedge clk);
        chk("hi_sel", 64'(wb_sel), 64'd2);
        #2 clear = 1'b1;
        #1;
        sb.delete();
        chk("rst2_valid", 64'(wb_valid), 64'd0);
        chk("rst2_data", 64'(wb_data), 64'd0);
        chk("rst2_sel", 64'(wb_sel), 64'd0);
        chk("rst2_z", {z_hi, z_lo}, 64'd0);
        chk("rst2_flags", {62'd0, zero_flag, neg_flag}, 64'd0);
        chk("rst2_busy", 64'(busy), 64'd0);
        @(posedge clk); #1; clear = 1'b0;
        idle_chk("rst2_rel");

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
